// File: rtl/pll_reset_ce_gen.sv
// Core reset and 16/4/1 MHz clock-enable generator driven by the 64 MHz PLL clock.
// Reset is held until PLL lock has been stable for SETTLE_CYCLES; lock loss in RUN is latched.
package pll_reset_ce_gen_pkg;
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;
endpackage

module pll_reset_ce_gen
    import pll_reset_ce_gen_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned SETTLE_W      = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       sys_rst,
    output logic       ce_16m,
    output logic       ce_4m,
    output logic       ce_1m,
    output logic       lock_lost,
    output logic [1:0] state
);

    logic                lk_s1;
    logic                lk_s2;
    state_t              state_q;
    state_t              state_d;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;
    logic [5:0]          div_q;
    logic [5:0]          div_d;
    logic                lock_lost_q;
    logic                lock_lost_d;
    logic                sys_rst_q;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        div_d       = div_q;
        lock_lost_d = lock_lost_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lk_s2) begin
                    state_d  = STABILIZE;
                    settle_d = '0;
                end
            end
            STABILIZE: begin
                if (!lk_s2) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_d = RUN;
                    div_d   = '0;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            RUN: begin
                if (!lk_s2) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else begin
                    div_d = div_q + 6'd1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_s1       <= 1'b0;
            lk_s2       <= 1'b0;
            state_q     <= WAIT_LOCK;
            settle_q    <= '0;
            div_q       <= '0;
            lock_lost_q <= 1'b0;
            sys_rst_q   <= 1'b1;
        end else begin
            lk_s1       <= locked;
            lk_s2       <= lk_s1;
            state_q     <= state_d;
            settle_q    <= settle_d;
            div_q       <= div_d;
            lock_lost_q <= lock_lost_d;
            // Registered from next state so reset drops on the same edge RUN is entered
            sys_rst_q   <= (state_d != RUN);
        end
    end

    always_comb begin
        ce_16m    = (state_q == RUN) && (div_q[1:0] == 2'b11);
        ce_4m     = (state_q == RUN) && (div_q[3:0] == 4'hF);
        ce_1m     = (state_q == RUN) && (div_q == 6'h3F);
        sys_rst   = sys_rst_q;
        lock_lost = lock_lost_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Scoreboard bench for pll_reset_ce_gen: per-edge expected outputs are queued with the stimulus
// and compared after each edge; a second instance covers the SETTLE_CYCLES=2 corner.
module tb_pll_reset_ce_gen;
    import pll_reset_ce_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       sys_rst, ce_16m, ce_4m, ce_1m, lock_lost;
    logic [1:0] state;
    logic       sys_rst2, ce_16m2, ce_4m2, ce_1m2, lock_lost2;
    logic [1:0] state2;

    pll_reset_ce_gen #(.SETTLE_CYCLES(16), .SETTLE_W(5)) dut (
        .clk(clk), .rst(rst), .locked(locked), .sys_rst(sys_rst), .ce_16m(ce_16m),
        .ce_4m(ce_4m), .ce_1m(ce_1m), .lock_lost(lock_lost), .state(state)
    );

    pll_reset_ce_gen #(.SETTLE_CYCLES(2), .SETTLE_W(2)) dut2 (
        .clk(clk), .rst(rst), .locked(locked), .sys_rst(sys_rst2), .ce_16m(ce_16m2),
        .ce_4m(ce_4m2), .ce_1m(ce_1m2), .lock_lost(lock_lost2), .state(state2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n16, n4, n1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs packed as {sys_rst, ce_16m, ce_4m, ce_1m, lock_lost, state}; div<0 means not running
    function automatic logic [6:0] mk_vec(input bit srst, input bit lost, input logic [1:0] st,
                                          input int div);
        logic c16, c4, c1;
        c16 = (div >= 0) && (div % 4 == 3);
        c4  = (div >= 0) && (div % 16 == 15);
        c1  = (div == 63);
        return {srst, c16, c4, c1, lost, st};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {sys_rst, ce_16m, ce_4m, ce_1m, lock_lost, state};
    endfunction

    task automatic step(input string tag, input bit srst, input bit lost, input logic [1:0] st,
                        input int div);
        exp_t e;
        e.tag = tag;
        e.vec = mk_vec(srst, lost, st, div);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {25'd0, obs_vec()}, {25'd0, e.vec});
        end
        n16 += int'(ce_16m);
        n4  += int'(ce_4m);
        n1  += int'(ce_1m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        locked = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_state", {25'd0, obs_vec()}, {25'd0, mk_vec(1, 0, 2'd0, -1)});
        check("rst_srst2", {31'd0, sys_rst2}, 32'd1);

        // Power-up: sys_rst released at edge 19 (SETTLE_CYCLES=16), edge 5 for the small instance
        rst = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            step($sformatf("pwr_e%0d", e), 1, 0, (e < 3) ? 2'd0 : 2'd1, -1);
            if (e <= 8) begin
                check($sformatf("s2_srst_e%0d", e), {31'd0, sys_rst2}, (e < 5) ? 32'd1 : 32'd0);
                check($sformatf("s2_state_e%0d", e), {30'd0, state2},
                      (e < 3) ? 32'd0 : (e < 5) ? 32'd1 : 32'd2);
            end
        end

        // Cadence over 256 RUN cycles
        n16 = 0; n4 = 0; n1 = 0;
        for (int k = 0; k < 256; k++) step($sformatf("run_k%0d", k), 0, 0, 2'd2, k % 64);
        check("cnt_16m", n16, 64);
        check("cnt_4m", n4, 16);
        check("cnt_1m", n1, 4);

        // Lock loss in RUN, then re-lock
        locked = 1'b0;
        step("loss_e1", 0, 0, 2'd2, 0);
        step("loss_e2", 0, 0, 2'd2, 1);
        step("loss_e3", 1, 1, 2'd0, -1);
        step("loss_e4", 1, 1, 2'd0, -1);
        locked = 1'b1;
        for (int e = 1; e <= 18; e++)
            step($sformatf("relock_e%0d", e), 1, 1, (e < 3) ? 2'd0 : 2'd1, -1);
        for (int k = 0; k <= 37; k++) step($sformatf("relock_k%0d", k), 0, 1, 2'd2, k);

        // rst mid-RUN at div_cnt=37
        rst = 1'b1;
        step("rst_mid", 1, 0, 2'd0, -1);
        check("rst_mid_div", {26'd0, dut.div_q}, 32'd0);
        rst = 1'b0;

        // Glitch in settle: lk_s2 low seen when settle_cnt=10
        for (int e = 1; e <= 11; e++)
            step($sformatf("gl_e%0d", e), 1, 0, (e < 3) ? 2'd0 : 2'd1, -1);
        locked = 1'b0;
        step("gl_e12", 1, 0, 2'd1, -1);
        step("gl_e13", 1, 0, 2'd1, -1);
        check("gl_settle", {27'd0, dut.settle_q}, 32'd10);
        step("gl_e14", 1, 0, 2'd0, -1);
        locked = 1'b1;
        for (int e = 15; e <= 32; e++)
            step($sformatf("gl_e%0d", e), 1, 0, (e < 17) ? 2'd0 : 2'd1, -1);
        for (int k = 0; k <= 3; k++) step($sformatf("gl_run_k%0d", k), 0, 0, 2'd2, k);

        // Illegal state 3 recovers to WAIT_LOCK
        force dut.state_q = state_t'(2'd3);
        #1;
        check("force_vec", {25'd0, obs_vec()}, {25'd0, mk_vec(0, 0, 2'd3, -1)});
        release dut.state_q;
        step("force_rec", 1, 0, 2'd0, -1);
        step("force_stab", 1, 0, 2'd1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
